// File: rtl/rx_channel_router_pkg.sv
// rx_channel_router_pkg: transaction-layer type codes, router FSM encoding and default burst map.
package rx_channel_router_pkg;
  localparam logic [3:0] TYPE_AW   = 4'd1;
  localparam logic [3:0] TYPE_AR   = 4'd2;
  localparam logic [3:0] TYPE_R    = 4'd3;
  localparam logic [3:0] TYPE_B    = 4'd4;
  localparam logic [3:0] TYPE_BAR0 = 4'd5;
  localparam logic [3:0] TYPE_BAR1 = 4'd6;
  localparam logic [4:0] DEF_BURST_MASK = 5'b00101;
  typedef enum logic [1:0] {ST_IDLE, ST_BURST, ST_DROP} state_t;
endpackage

// File: rtl/rx_chan_fifo.sv
// rx_chan_fifo: first-word-fall-through FIFO; read data reads as zero while empty.
module rx_chan_fifo #(
  parameter int WIDTH = 129,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wp, rp;
  assign valid = wp != rp;
  assign full  = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
  assign rdata = valid ? mem[rp[AW-1:0]] : '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) begin
        mem[wp[AW-1:0]] <= wdata;
        wp <= wp + 1'b1;
      end
      if (pop && valid) rp <= rp + 1'b1;
    end
  end
endmodule

// File: rtl/rx_channel_router.sv
// rx_channel_router: decodes each packet header type and steers the packet into a per-channel FIFO,
// stamping the connection ID and dropping/counting malformed packets.
module rx_channel_router
  import rx_channel_router_pkg::*;
#(
  parameter int               DATA_WIDTH = 16,
  parameter int               TYPE_W     = 4,
  parameter int               CID_W      = 4,
  parameter int               NUM_CH     = 5,
  parameter logic [NUM_CH-1:0] BURST_MASK = DEF_BURST_MASK,
  parameter bit               ALIAS_LAST = 1'b1,
  parameter int               FIFO_DEPTH = 4,
  parameter int               CNT_W      = 16
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH*8-1:0]        rx_data,
  input  logic [CID_W-1:0]               rx_connection_id,
  input  logic                           rx_last,
  input  logic                           rx_valid,
  output logic                           rx_ready,
  output logic [NUM_CH*DATA_WIDTH*8-1:0] ch_data,
  output logic [NUM_CH-1:0]              ch_last,
  output logic [NUM_CH-1:0]              ch_valid,
  input  logic [NUM_CH-1:0]              ch_ready,
  output logic [CNT_W-1:0]               drop_count
);
  localparam int W = DATA_WIDTH * 8;
  localparam int CH_W = $clog2(NUM_CH);
  localparam logic [TYPE_W-1:0] T_LAST  = TYPE_W'(NUM_CH);
  localparam logic [TYPE_W-1:0] T_ALIAS = TYPE_W'(NUM_CH + 1);
  state_t state;
  logic [CH_W-1:0] lock_ch, tgt, cur_ch;
  logic [TYPE_W-1:0] t;
  logic has_tgt, is_alias, burst_ch, accept, push_any, drop_inc, wr_last;
  logic [NUM_CH-1:0] full;
  logic [W-1:0] hdr, wr_data;
  assign t        = rx_data[TYPE_W-1:0];
  assign has_tgt  = (t != '0 && t <= T_LAST) || (ALIAS_LAST && t == T_ALIAS);
  assign is_alias = t == T_LAST || (ALIAS_LAST && t == T_ALIAS);
  assign tgt      = (ALIAS_LAST && t == T_ALIAS) ? CH_W'(NUM_CH - 1) : CH_W'(t - 1'b1);
  assign burst_ch = BURST_MASK[tgt];
  assign cur_ch   = state == ST_IDLE ? tgt : lock_ch;
  // A header with no target is always taken so it can be dropped without stalling.
  assign rx_ready = !reset && (state == ST_DROP || (state == ST_IDLE && !has_tgt) || !full[cur_ch]);
  assign accept   = rx_valid && rx_ready;
  assign push_any = accept && (state == ST_BURST || (state == ST_IDLE && has_tgt));
  assign drop_inc = accept && state == ST_IDLE && (!has_tgt || (!burst_ch && !rx_last));
  assign hdr = is_alias ? {rx_data[W-1:9], rx_data[0], rx_data[7:4], 4'(rx_connection_id)}
                        : {rx_data[W-1:TYPE_W], TYPE_W'(rx_connection_id)};
  assign wr_data = state == ST_IDLE ? hdr : rx_data;
  assign wr_last = rx_last || (state == ST_IDLE && !burst_ch);
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    rx_chan_fifo #(.WIDTH(W + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push_any && cur_ch == CH_W'(c)),
      .wdata ({wr_last, wr_data}),
      .full  (full[c]),
      .pop   (ch_ready[c]),
      .rdata ({ch_last[c], ch_data[c*W +: W]}),
      .valid (ch_valid[c])
    );
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      lock_ch    <= '0;
      drop_count <= '0;
    end else begin
      if (drop_inc && !(&drop_count)) drop_count <= drop_count + 1'b1;
      if (accept) begin
        case (state)
          ST_IDLE:
            if (has_tgt && burst_ch && !rx_last) begin
              state   <= ST_BURST;
              lock_ch <= tgt;
            end else if (!rx_last) state <= ST_DROP;
          default: if (rx_last) state <= ST_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_rx_channel_router.sv
// tb_rx_channel_router: directed packets with hand-computed expectations queued per channel;
// a negedge monitor pops and compares every channel handshake.
module tb_rx_channel_router;
  localparam int W = 128, N = 5;
  localparam logic [119:0] U  = 120'h0123_4567_89AB_CDEF_0011_2233_4455_66;
  localparam logic [115:0] U1 = 116'h0123_4567_89AB_CDEF_0011_2233_4455_6;
  logic clk = 0, reset = 1;
  logic [W-1:0] rx_data = '0;
  logic [3:0] rx_connection_id = '0;
  logic rx_last = 0, rx_valid = 0, rx_ready;
  logic [N*W-1:0] ch_data;
  logic [N-1:0] ch_last, ch_valid, ch_ready = '1;
  logic [15:0] drop_count;
  int applied = 0, miscompares = 0;
  logic [W:0] exp_q [N][$];
  always #5 clk = ~clk;
  rx_channel_router dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_connection_id(rx_connection_id),
    .rx_last(rx_last), .rx_valid(rx_valid), .rx_ready(rx_ready), .ch_data(ch_data),
    .ch_last(ch_last), .ch_valid(ch_valid), .ch_ready(ch_ready), .drop_count(drop_count)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    applied++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask
  task automatic send(input logic [W-1:0] d, input logic [3:0] cid, input logic last,
                      input int ch, input logic [W-1:0] ed, input logic el);
    int n = 0;
    rx_data = d; rx_connection_id = cid; rx_last = last; rx_valid = 1;
    @(negedge clk);
    while (!rx_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!rx_ready) begin
      applied++;
      miscompares++;
      $display("FAIL accept_timeout: beat %0h never accepted", d);
    end else if (ch >= 0) exp_q[ch].push_back({el, ed});
    @(posedge clk);
    #1 rx_valid = 0;
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      for (int c = 0; c < N; c++) begin
        if (ch_valid[c] && ch_ready[c]) begin
          logic [W:0] e;
          applied++;
          if (exp_q[c].size() == 0) begin
            miscompares++;
            $display("FAIL ch%0d_unexpected: got %0h want nothing", c, {ch_last[c], ch_data[c*W +: W]});
          end else begin
            e = exp_q[c].pop_front();
            if ({ch_last[c], ch_data[c*W +: W]} !== e) begin
              miscompares++;
              $display("FAIL ch%0d_beat: got %0h want %0h", c, {ch_last[c], ch_data[c*W +: W]}, e);
            end
          end
        end
      end
    end
  end
  initial begin
    int n;
    @(negedge clk);
    chk("reset_rx_ready", rx_ready, 0);
    chk("reset_ch_valid", ch_valid, 0);
    chk("reset_drop", drop_count, 0);
    @(posedge clk);
    #1 reset = 0;
    // ar single beat, cid stamped into low nibble
    send({U, 8'h52}, 4'hA, 1, 1, {U, 8'h5A}, 1);
    // aw burst fills stalled ch0; b header still passes to ch3
    ch_ready[0] = 0;
    send({U, 8'h11}, 4'h5, 0, 0, {U, 8'h15}, 0);
    send({U1, 12'hB02}, 4'h5, 0, 0, {U1, 12'hB02}, 0);
    send({U1, 12'hB03}, 4'h5, 0, 0, {U1, 12'hB03}, 0);
    send({U1, 12'hB04}, 4'h5, 1, 0, {U1, 12'hB04}, 1);
    rx_data = {U, 8'h21}; rx_connection_id = 4'h2; rx_last = 1; rx_valid = 1;
    @(negedge clk);
    chk("aw_full_ready", rx_ready, 0);
    chk("ch0_held", ch_valid[0], 1);
    @(posedge clk);
    #1 rx_valid = 0;
    send({U, 8'h34}, 4'h7, 1, 3, {U, 8'h37}, 1);
    ch_ready[0] = 1;
    send({U, 8'h21}, 4'h2, 1, 0, {U, 8'h22}, 1);
    // barrier rewrite for both alias types
    send({U1, 4'h6, 8'h75}, 4'h3, 1, 4, {U1, 4'h7, 8'h73}, 1);
    send({U1, 4'h6, 8'h86}, 4'h9, 1, 4, {U1, 4'h6, 8'h89}, 1);
    // unknown type: whole packet dropped
    send({U, 8'h0F}, 4'h1, 0, -1, '0, 0);
    send({U1, 12'hC01}, 4'h1, 0, -1, '0, 0);
    send({U1, 12'hC02}, 4'h1, 1, -1, '0, 0);
    @(negedge clk);
    chk("drop_count_1", drop_count, 1);
    chk("drop_no_output", ch_valid, 0);
    @(posedge clk);
    #1;
    send({U, 8'h43}, 4'h1, 0, 2, {U, 8'h41}, 0);
    send({U1, 12'hD01}, 4'h1, 1, 2, {U1, 12'hD01}, 1);
    // multi-beat packet on single-beat channel: header kept, tail dropped
    send({U, 8'h62}, 4'h4, 0, 1, {U, 8'h64}, 1);
    send({U1, 12'hE01}, 4'h4, 0, -1, '0, 0);
    send({U1, 12'hE02}, 4'h4, 1, -1, '0, 0);
    @(negedge clk);
    chk("drop_count_2", drop_count, 2);
    @(posedge clk);
    #1 ch_ready[2] = 0;
    // reset in the middle of an r burst
    send({U, 8'h43}, 4'h1, 0, -1, '0, 0);
    send({U1, 12'hF01}, 4'h1, 0, -1, '0, 0);
    reset = 1;
    @(negedge clk);
    chk("midreset_rx_ready", rx_ready, 0);
    @(posedge clk);
    #1;
    chk("midreset_ch_valid", ch_valid, 0);
    chk("midreset_drop", drop_count, 0);
    reset = 0;
    ch_ready[2] = 1;
    send({U, 8'h72}, 4'h1, 1, 1, {U, 8'h71}, 1);
    n = 0;
    while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size() + exp_q[4].size()) != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    for (int c = 0; c < N; c++) chk($sformatf("ch%0d_drained", c), exp_q[c].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end
endmodule
